// File: rtl/run_detect_arbiter_if.sv
// Bundle between serial requesters and the shared run detector.
// The master side drives req/w; the slave side (the arbiter) returns grant and burst results.
interface run_detect_arbiter_if #(
  parameter int NREQ  = 4,
  parameter int BURST = 8
);
  localparam int IDW = $clog2(NREQ);
  localparam int HW  = $clog2(BURST + 1);

  logic [NREQ-1:0] req;
  logic [NREQ-1:0] w;
  logic [NREQ-1:0] gnt;
  logic            s;
  logic            done;
  logic [IDW-1:0]  done_id;
  logic [HW-1:0]   hits;
  logic            abort;

  modport master (output req, w, input gnt, s, done, done_id, hits, abort);
  modport slave  (input req, w, output gnt, s, done, done_id, hits, abort);
endinterface

// File: rtl/run_detect_arbiter.sv
// Round-robin arbiter sharing one bit-serial run detector among NREQ lanes, one BURST per grant.
// Define RDA_ONES_ONLY_EN to count only runs of ones; by default runs of zeros also count.
module run_detect_arbiter #(
  parameter int NREQ  = 4,
  parameter int BURST = 8,
  parameter int RUN   = 4
) (
  input  logic                clk,
  input  logic                reset,
  run_detect_arbiter_if.slave bus
);
  localparam int IDW = $clog2(NREQ);
  localparam int HW  = $clog2(BURST + 1);
  localparam int CW  = $clog2(RUN + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t          state_q, state_d;
  logic [IDW-1:0]  gid_q, ptr_q;
  logic [IDW-1:0]  winner, idxW;
  logic            found;
  int              idx;
  logic [RUN-1:0]  hist_q, histNew;
  logic [CW-1:0]   cnt_q, cntNew;
  logic [HW-1:0]   bitCnt_q, hits_q;
  logic            s_q, abort_q;
  logic            reqGid, wGid, lastBit, detect;
  logic [NREQ-1:0] gnt;
  logic            done;

  assign reqGid  = bus.req[gid_q];
  assign wGid    = bus.w[gid_q];
  assign lastBit = (bitCnt_q == HW'(BURST - 1));

  // Winner is the first requesting lane at or above ptr, wrapping around.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    idx    = 0;
    idxW   = '0;
    for (int i = 0; i < NREQ; i++) begin
      idx  = (int'(ptr_q) + i) % NREQ;
      idxW = IDW'(idx);
      if (!found && bus.req[idxW]) begin
        found  = 1'b1;
        winner = idxW;
      end
    end
  end

  // The run counter saturates at RUN, so reaching RUN means the whole history is from this burst.
  always_comb begin
    histNew = {hist_q[RUN-2:0], wGid};
    cntNew  = (cnt_q == CW'(RUN)) ? cnt_q : cnt_q + CW'(1);
`ifdef RDA_ONES_ONLY_EN
    detect  = (cntNew == CW'(RUN)) && (&histNew);
`else
    detect  = (cntNew == CW'(RUN)) && ((&histNew) || !(|histNew));
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (found) state_d = SHIFT;
      SHIFT:   if (!reqGid || lastBit) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    gnt  = '0;
    done = 1'b0;
    case (state_q)
      SHIFT:   gnt[gid_q] = 1'b1;
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  // Burst datapath; results from the last burst stay visible until the next grant clears them.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      gid_q    <= '0;
      ptr_q    <= '0;
      hist_q   <= '0;
      cnt_q    <= '0;
      bitCnt_q <= '0;
      hits_q   <= '0;
      s_q      <= 1'b0;
      abort_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (found) begin
            gid_q    <= winner;
            ptr_q    <= (winner == IDW'(NREQ - 1)) ? '0 : winner + IDW'(1);
            hist_q   <= '0;
            cnt_q    <= '0;
            bitCnt_q <= '0;
            hits_q   <= '0;
            s_q      <= 1'b0;
            abort_q  <= 1'b0;
          end
        end
        SHIFT: begin
          if (!reqGid) begin
            s_q     <= 1'b0;
            abort_q <= 1'b1;
          end else begin
            hist_q   <= histNew;
            cnt_q    <= cntNew;
            bitCnt_q <= bitCnt_q + HW'(1);
            s_q      <= detect;
            hits_q   <= hits_q + HW'(detect);
          end
        end
        DONE:    s_q <= 1'b0;
        default: ;
      endcase
    end
  end

  assign bus.gnt     = gnt;
  assign bus.done    = done;
  assign bus.s       = s_q;
  assign bus.done_id = gid_q;
  assign bus.hits    = hits_q;
  assign bus.abort   = abort_q;
endmodule

// File: tb/tb_run_detect_arbiter.sv
// Directed and randomized bursts on the run-detect arbiter, checked against a
// behavioural model of round-robin choice and run counting over the sampled bits.
module tb_run_detect_arbiter;
  localparam int NREQ  = 4;
  localparam int BURST = 8;
  localparam int RUN   = 4;

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;
  int   ptrM  = 0;

  run_detect_arbiter_if #(.NREQ(NREQ), .BURST(BURST)) bus ();

  run_detect_arbiter #(.NREQ(NREQ), .BURST(BURST), .RUN(RUN)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // A run is present when the last RUN sampled bits are all ones (or all zeros unless ones-only).
  function automatic logic expectS(input logic [BURST-1:0] seen, input int n);
    int ones;
    ones = 0;
    if (n < RUN) return 1'b0;
    for (int j = n - RUN; j < n; j++) ones += int'(seen[j]);
`ifdef RDA_ONES_ONLY_EN
    return (ones == RUN);
`else
    return (ones == RUN) || (ones == 0);
`endif
  endfunction

  function automatic int pickWinner(input logic [NREQ-1:0] mask);
    for (int i = 0; i < NREQ; i++) begin
      if (mask[(ptrM + i) % NREQ]) return (ptrM + i) % NREQ;
    end
    return -1;
  endfunction

  // Called at a negedge with the DUT idle; returns at the idle negedge after the burst.
  // dropAt=k lowers the granted request before bit k (0 = full burst).
  task automatic applyStimulus(input logic [NREQ-1:0] mask, input int dropAt,
                               input bit useBits, input logic [BURST-1:0] bits);
    int               g;
    int               hitsM;
    logic [BURST-1:0] seen;
    logic             b;
    logic             sM;
    bit               aborted;
    seen    = '0;
    hitsM   = 0;
    aborted = 1'b0;
    g       = pickWinner(mask);
    ptrM    = (g + 1) % NREQ;
    bus.req = mask;
    bus.w   = NREQ'($urandom);
    @(negedge clk);
    checkOutput("gnt_start", 32'(bus.gnt), 32'(1) << g);
    checkOutput("s_start", 32'(bus.s), 32'(0));
    for (int k = 1; k <= BURST && !aborted; k++) begin
      b = useBits ? bits[k-1] : 1'($urandom);
      bus.w    = NREQ'($urandom);
      bus.w[g] = b;
      if (k == dropAt) bus.req[g] = 1'b0;
      @(negedge clk);
      if (k == dropAt) begin
        aborted = 1'b1;
        checkOutput("abort_done", 32'(bus.done), 32'(1));
        checkOutput("abort_flag", 32'(bus.abort), 32'(1));
        checkOutput("abort_hits", 32'(bus.hits), 32'(hitsM));
        checkOutput("abort_id", 32'(bus.done_id), 32'(g));
        checkOutput("abort_gnt", 32'(bus.gnt), 32'(0));
        checkOutput("abort_s", 32'(bus.s), 32'(0));
      end else begin
        seen[k-1] = b;
        sM        = expectS(seen, k);
        hitsM    += int'(sM);
        checkOutput("s", 32'(bus.s), 32'(sM));
        if (k < BURST) begin
          checkOutput("gnt", 32'(bus.gnt), 32'(1) << g);
        end else begin
          checkOutput("end_gnt", 32'(bus.gnt), 32'(0));
          checkOutput("done", 32'(bus.done), 32'(1));
          checkOutput("done_id", 32'(bus.done_id), 32'(g));
          checkOutput("hits", 32'(bus.hits), 32'(hitsM));
          checkOutput("abort", 32'(bus.abort), 32'(0));
        end
      end
    end
    bus.req = '0;
    bus.w   = '0;
    @(negedge clk);
    checkOutput("idle_done", 32'(bus.done), 32'(0));
    checkOutput("idle_gnt", 32'(bus.gnt), 32'(0));
    checkOutput("idle_hits", 32'(bus.hits), 32'(hitsM));
  endtask

  initial begin
    int g;
    logic [NREQ-1:0] mask;
    int drop;

    reset   = 1'b1;
    bus.req = '0;
    bus.w   = '0;
    repeat (2) @(negedge clk);
    checkOutput("rst_gnt", 32'(bus.gnt), 32'(0));
    checkOutput("rst_s", 32'(bus.s), 32'(0));
    checkOutput("rst_done", 32'(bus.done), 32'(0));
    checkOutput("rst_hits", 32'(bus.hits), 32'(0));
    checkOutput("rst_abort", 32'(bus.abort), 32'(0));
    checkOutput("rst_id", 32'(bus.done_id), 32'(0));
    reset = 1'b0;
    @(negedge clk);

    $display("[TB] lane 0 constant ones");
    applyStimulus(4'b0001, 0, 1'b1, 8'hFF);
    checkOutput("tp_ones_hits", 32'(bus.hits), 32'(5));

    $display("[TB] lane 1 pattern 1,1,0,0,0,0,1,1");
    applyStimulus(4'b0010, 0, 1'b1, 8'b1100_0011);
`ifdef RDA_ONES_ONLY_EN
    checkOutput("tp_pattern_hits", 32'(bus.hits), 32'(0));
`else
    checkOutput("tp_pattern_hits", 32'(bus.hits), 32'(1));
`endif

    $display("[TB] all requests held");
    for (int i = 0; i < 5; i++) applyStimulus(4'b1111, 0, 1'b0, '0);

    $display("[TB] lane 2 history clear across bursts");
    applyStimulus(4'b0100, 0, 1'b1, 8'b1110_0101);
    applyStimulus(4'b0100, 0, 1'b1, 8'b0000_1011);

    $display("[TB] lane 0 request dropped after 5 bits");
    applyStimulus(4'b0001, 6, 1'b1, 8'hFF);
    checkOutput("tp_abort_hits", 32'(bus.hits), 32'(2));

    $display("[TB] reset mid-burst");
    bus.req = 4'b0100;
    g       = pickWinner(4'b0100);
    bus.w   = '1;
    repeat (6) @(negedge clk);
    checkOutput("mid_gnt", 32'(bus.gnt), 32'(1) << g);
    checkOutput("mid_hits", 32'(bus.hits), 32'(2));
    #2 reset = 1'b1;
    #1;
    checkOutput("mid_rst_gnt", 32'(bus.gnt), 32'(0));
    checkOutput("mid_rst_s", 32'(bus.s), 32'(0));
    checkOutput("mid_rst_done", 32'(bus.done), 32'(0));
    checkOutput("mid_rst_hits", 32'(bus.hits), 32'(0));
    bus.req = '0;
    bus.w   = '0;
    @(negedge clk);
    reset = 1'b0;
    ptrM  = 0;
    @(negedge clk);
    applyStimulus(4'b1010, 0, 1'b0, '0);
    checkOutput("post_rst_id", 32'(bus.done_id), 32'(1));

    $display("[TB] randomized bursts");
    for (int i = 0; i < 12; i++) begin
      mask = NREQ'($urandom_range(1, (1 << NREQ) - 1));
      drop = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, BURST)) : 0;
      applyStimulus(mask, drop, 1'b0, '0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
